// File: rtl/mb32_feed.sv
// mb32_feed: credit-gated feeder between an operand queue and an external Booth multiplier.
// Operands issue one edge after acceptance; products return LAT edges after issue, in order.

module mb32_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   push,
    input  logic [W-1:0]           push_dat,
    input  logic                   pop,
    output logic [W-1:0]           head_dat,
    output logic [$clog2(DEPTH):0] cnt
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wptr_q, wptr_d;
    logic [AW:0]  rptr_q, rptr_d;
    logic [W-1:0] mem_q [DEPTH];

    always_comb begin
        wptr_d = wptr_q + {{AW{1'b0}}, push};
        rptr_d = rptr_q + {{AW{1'b0}}, pop};
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage is not reset: an entry is only visible once the write pointer has passed it.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem_q[wptr_q[AW-1:0]] <= push_dat;
        end
    end

    assign head_dat = mem_q[rptr_q[AW-1:0]];
    assign cnt      = wptr_q - rptr_q;
endmodule

module mb32_feed #(
    parameter int WIDTH = 32,
    parameter int LAT   = 2,
    parameter int DEPTH = 4
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    output logic [WIDTH-1:0]     mx1,
    output logic [WIDTH-1:0]     my1,
    input  logic [2*WIDTH-1:0]   product1,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_prod,
    output logic                 busy
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [CW-1:0]      in_cnt;
    logic [CW-1:0]      res_cnt;
    logic [CW-1:0]      infl_q, infl_d;
    logic [CW:0]        outstanding;
    logic [2*WIDTH-1:0] in_head;
    logic [2*WIDTH-1:0] res_head;
    logic               in_push;
    logic               issue;
    logic               res_push;
    logic               res_pop;
    logic [LAT-1:0]     tag_q, tag_d;
    logic [WIDTH-1:0]   mx1_q, mx1_d;
    logic [WIDTH-1:0]   my1_q, my1_d;

    mb32_fifo #(.W(2*WIDTH), .DEPTH(DEPTH)) u_in_q (
        .CLK      (CLK),
        .RST      (RST),
        .push     (in_push),
        .push_dat ({in_a, in_b}),
        .pop      (issue),
        .head_dat (in_head),
        .cnt      (in_cnt)
    );

    mb32_fifo #(.W(2*WIDTH), .DEPTH(DEPTH)) u_res_q (
        .CLK      (CLK),
        .RST      (RST),
        .push     (res_push),
        .push_dat (product1),
        .pop      (res_pop),
        .head_dat (res_head),
        .cnt      (res_cnt)
    );

    always_comb begin
        in_ready    = (in_cnt != CW'(DEPTH));
        in_push     = in_valid && in_ready;
        // Credits count results already queued plus products still in the multiplier,
        // both taken before this edge, so a same-edge pop never frees a slot early.
        outstanding = {1'b0, infl_q} + {1'b0, res_cnt};
        issue       = (in_cnt != '0) && (outstanding < (CW+1)'(DEPTH));
        res_push    = tag_q[LAT-1];
        out_valid   = (res_cnt != '0);
        res_pop     = out_valid && out_ready;
        tag_d       = (tag_q << 1) | LAT'(issue);
        infl_d      = infl_q + CW'(issue) - CW'(res_push);
        mx1_d       = issue ? in_head[2*WIDTH-1:WIDTH] : '0;
        my1_d       = issue ? in_head[WIDTH-1:0] : '0;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            tag_q  <= '0;
            infl_q <= '0;
            mx1_q  <= '0;
            my1_q  <= '0;
        end else begin
            tag_q  <= tag_d;
            infl_q <= infl_d;
            mx1_q  <= mx1_d;
            my1_q  <= my1_d;
        end
    end

    assign mx1      = mx1_q;
    assign my1      = my1_q;
    assign out_prod = out_valid ? res_head : '0;
    assign busy     = (in_cnt != '0) || (infl_q != '0) || out_valid;
endmodule

// File: tb/tb_mb32_feed.sv
// Bench for mb32_feed: ideal signed multiplier delayed LAT edges, scoreboard of a*b in acceptance order.
module tb_mb32_feed;
    localparam int WIDTH = 32;
    localparam int LAT   = 2;
    localparam int DEPTH = 4;

    logic               CLK = 1'b0;
    logic               RST;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_a;
    logic [WIDTH-1:0]   in_b;
    logic [WIDTH-1:0]   mx1;
    logic [WIDTH-1:0]   my1;
    logic [2*WIDTH-1:0] product1;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] out_prod;
    logic               busy;

    mb32_feed #(.WIDTH(WIDTH), .LAT(LAT), .DEPTH(DEPTH)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .mx1       (mx1),
        .my1       (my1),
        .product1  (product1),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_prod  (out_prod),
        .busy      (busy)
    );

    always #5 CLK = ~CLK;

    function automatic logic [63:0] smul(input logic [31:0] a, input logic [31:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        return 64'(p);
    endfunction

    // Ideal multiplier: product of the operands registered at edge e is presented for edge e+LAT.
    logic [63:0] pipe [0:7];
    always @(posedge CLK) begin
        pipe[0] <= smul(mx1, my1);
        for (int i = 1; i < 8; i++) pipe[i] <= pipe[i-1];
    end
    assign product1 = pipe[LAT-2];

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          first_pop;
    int          last_pop;
    bit          last_in_fire;
    bit          prev_stall;
    logic [63:0] prev_prod;
    logic [63:0] exp_q[$];
    logic [63:0] got_q[$];
    logic [31:0] src_a[$];
    logic [31:0] src_b[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic reset_checks(input string pfx);
        check({pfx, "_mx1"}, mx1, 64'd0);
        check({pfx, "_my1"}, my1, 64'd0);
        check({pfx, "_in_ready"}, in_ready, 64'd1);
        check({pfx, "_out_valid"}, out_valid, 64'd0);
        check({pfx, "_out_prod"}, out_prod, 64'd0);
        check({pfx, "_busy"}, busy, 64'd0);
    endtask

    // One clock: predict transfers from the levels settled before the edge, then advance.
    task automatic cycle();
        bit in_fire;
        bit out_fire;
        in_fire  = in_valid && in_ready;
        out_fire = out_valid && out_ready;
        if (prev_stall && out_valid) check("hold_stable", out_prod, prev_prod);
        if (out_fire) begin
            check("sb_nonempty", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) check("sb_data", out_prod, exp_q.pop_front());
            got_q.push_back(out_prod);
            if (first_pop < 0) first_pop = cyc;
            last_pop = cyc;
        end
        if (in_fire) exp_q.push_back(smul(in_a, in_b));
        prev_stall = out_valid && !out_ready;
        prev_prod  = out_prod;
        @(posedge CLK);
        #1;
        cyc++;
        last_in_fire = in_fire;
    endtask

    task automatic feed(input int budget, input bit rnd, input bit need_all);
        while (src_a.size() > 0 && budget > 0) begin
            in_a     = src_a[0];
            in_b     = src_b[0];
            in_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (rnd) out_ready = ($urandom_range(0, 2) != 0);
            cycle();
            if (last_in_fire) begin
                void'(src_a.pop_front());
                void'(src_b.pop_front());
            end
            budget--;
        end
        in_valid = 1'b0;
        if (need_all) check("feed_done", 64'(src_a.size()), 64'd0);
    endtask

    task automatic drain(input int budget);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while ((exp_q.size() > 0 || busy) && budget > 0) begin
            cycle();
            budget--;
        end
        check("drain_empty", 64'(exp_q.size()), 64'd0);
        check("drain_idle", busy, 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        RST = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_a = '0; in_b = '0;
        prev_stall = 1'b0; prev_prod = '0; first_pop = -1; last_pop = -1;
        repeat (3) @(posedge CLK);
        #1;
        reset_checks("rst");
        RST = 1'b0;

        // Single op 3 x -5, accepted on the first edge after reset release.
        in_a = 32'd3; in_b = 32'hFFFF_FFFB; in_valid = 1'b1; out_ready = 1'b1;
        cycle();
        in_valid = 1'b0;
        check("single_no_early_issue", mx1, 64'd0);
        check("single_busy", busy, 64'd1);
        cycle();
        check("single_mx1", mx1, 64'd3);
        check("single_my1", my1, 64'h0000_0000_FFFF_FFFB);
        repeat (LAT - 1) cycle();
        check("single_mx1_idle", mx1, 64'd0);
        check("single_no_early_valid", out_valid, 64'd0);
        cycle();
        check("single_valid", out_valid, 64'd1);
        check("single_prod", out_prod, 64'hFFFF_FFFF_FFFF_FFF1);
        cycle();
        check("single_pop_valid", out_valid, 64'd0);
        check("single_busy_after", busy, 64'd0);

        // Back-to-back (i, i+1).
        got_q.delete(); first_pop = -1;
        for (int i = 0; i < 8; i++) begin
            src_a.push_back(32'(i));
            src_b.push_back(32'(i + 1));
        end
        out_ready = 1'b1;
        feed(50, 1'b0, 1'b1);
        drain(50);
        check("b2b_count", 64'(got_q.size()), 64'd8);
        check("b2b_rate", 64'(last_pop - first_pop), 64'd7);
        for (int i = 0; i < 8; i++) check("b2b_value", got_q[i], 64'(i * (i + 1)));

        // Backpressure: 10 offered, only 2*DEPTH can be absorbed.
        got_q.delete(); out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            src_a.push_back($urandom | 32'd1);
            src_b.push_back($urandom | 32'd1);
        end
        feed(16, 1'b0, 1'b0);
        check("bp_pending", 64'(src_a.size()), 64'(10 - 2*DEPTH));
        check("bp_in_ready", in_ready, 64'd0);
        check("bp_out_valid", out_valid, 64'd1);
        repeat (3) begin
            cycle();
            check("bp_no_issue", mx1, 64'd0);
        end
        check("bp_no_pop", 64'(got_q.size()), 64'd0);
        out_ready = 1'b1;
        feed(100, 1'b0, 1'b1);
        drain(100);
        check("bp_count", 64'(got_q.size()), 64'd10);

        // Extreme operands.
        got_q.delete();
        src_a.push_back(32'h8000_0000); src_b.push_back(32'h8000_0000);
        src_a.push_back(32'hFFFF_FFFF); src_b.push_back(32'h0000_0001);
        out_ready = 1'b1;
        feed(20, 1'b0, 1'b1);
        drain(30);
        check("ext_min_sq", got_q[0], 64'h4000_0000_0000_0000);
        check("ext_neg_one", got_q[1], 64'hFFFF_FFFF_FFFF_FFFF);

        // Reset with two products in flight and three operands queued.
        out_ready = 1'b0;
        for (int i = 0; i < 12; i++) begin
            src_a.push_back($urandom | 32'd1);
            src_b.push_back($urandom | 32'd1);
        end
        feed(16, 1'b0, 1'b0);
        in_a = src_a[0]; in_b = src_b[0]; in_valid = 1'b1; out_ready = 1'b1;
        cycle();
        cycle();
        out_ready = 1'b0;
        cycle();
        check("mid_busy", busy, 64'd1);
        RST = 1'b1; in_valid = 1'b0;
        #1;
        reset_checks("mid_rst");
        exp_q.delete(); src_a.delete(); src_b.delete(); prev_stall = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        reset_checks("mid_hold");
        RST = 1'b0;
        got_q.delete();
        src_a.push_back(32'd7); src_b.push_back(32'd6);
        out_ready = 1'b1;
        feed(10, 1'b0, 1'b1);
        drain(30);
        check("post_rst_count", 64'(got_q.size()), 64'd1);
        check("post_rst_prod", got_q[0], 64'd42);

        // Pointer wrap under random stalls.
        got_q.delete();
        for (int i = 0; i < 3*DEPTH + 1; i++) begin
            src_a.push_back($urandom);
            src_b.push_back($urandom);
        end
        feed(2000, 1'b1, 1'b1);
        drain(200);
        check("wrap_count", 64'(got_q.size()), 64'(3*DEPTH + 1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mb32_feed.md
MB32_FEED -- requirements
Module: mb32_feed

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width.
REQ-002 SHALL have parameter LAT, default 2, multiplier latency in cycles from mx1/my1 register update to valid product1 sample (range 1..8).
REQ-003 SHALL have parameter DEPTH, default 4, entries in each of the input and result queues (power of two, 2..16).
REQ-004 CLK  input  1  single clock; all state updates on posedge.
REQ-005 RST  input  1  asynchronous, active-high reset.
REQ-006 in_valid  input  1  operand pair offered.
REQ-007 in_ready  output  1  input queue can accept.
REQ-008 in_a  input  WIDTH  multiplicand, signed two's complement.
REQ-009 in_b  input  WIDTH  multiplier, signed two's complement.
REQ-010 mx1  output  WIDTH  registered operand A to the Booth multiplier.
REQ-011 my1  output  WIDTH  registered operand B to the Booth multiplier.
REQ-012 product1  input  2*WIDTH  product returned by the multiplier.
REQ-013 out_valid  output  1  result queue non-empty.
REQ-014 out_ready  input  1  consumer accepts result.
REQ-015 out_prod  output  2*WIDTH  head of result queue.
REQ-016 busy  output  1  any queue non-empty or any product in flight.

Function
REQ-017 Input transfer SHALL occur on a posedge where in_valid and in_ready are both 1; in_ready SHALL equal NOT(input queue full), with no combinational path from out_ready or in_valid.
REQ-018 Issue SHALL occur on a posedge where the input queue is non-empty and outstanding < DEPTH, where outstanding = in-flight count + result queue count, both sampled before that edge.
REQ-019 On issue, mx1/my1 SHALL load the input queue head and the head SHALL be popped; on any other edge, mx1/my1 SHALL load 0.
REQ-020 A valid-tag shift register of LAT stages SHALL track issues; when an issue tag reaches stage LAT, product1 SHALL be pushed into the result queue on that same edge.
REQ-021 An item accepted at edge t SHALL issue no earlier than edge t+1; its product SHALL be captured no earlier than edge t+1+LAT; out_valid SHALL rise no earlier than immediately after that edge.
REQ-022 A result pop on the same edge as an issue decision SHALL NOT free a credit until the following edge.
REQ-023 Input queue FIFO order SHALL be preserved; results SHALL emerge in issue order.
REQ-024 Simultaneous input push and pop SHALL be legal when full: push is blocked (in_ready=0) and pop proceeds.
REQ-025 Simultaneous result push and pop SHALL be legal in every occupancy state; the credit rule guarantees the result queue never overflows.
REQ-026 Read and write pointers SHALL wrap modulo DEPTH; full/empty SHALL be distinguished by an extra pointer bit or a count.
REQ-027 out_prod SHALL be stable while out_valid=1 and out_ready=0.
REQ-028 No arithmetic SHALL be performed on operand or product data; widths pass through unchanged.
REQ-029 busy SHALL be 1 whenever input count, in-flight count or result count is non-zero.

Reset
REQ-030 RST=1 SHALL asynchronously clear both queues, all pointers and counts, and the tag shift register.
REQ-031 During and after reset: mx1=0, my1=0, in_ready=1, out_valid=0, out_prod=0, busy=0.
REQ-032 Reset mid-operation SHALL discard all queued and in-flight items; no product sampled after RST deassertion may be attributed to a pre-reset issue.
REQ-033 The first input transfer SHALL be accepted on the first posedge after RST deasserts.

Verification (bench models the multiplier as ideal signed multiply delayed LAT cycles)
REQ-034 Single op: in_a=3, in_b=-5 at edge 0, out_ready=1 -> mx1=3, my1=-5 after edge 1; out_prod=-15 with out_valid=1 after edge 1+LAT; busy=0 one edge after the pop.
REQ-035 Back-to-back: 8 pairs (i, i+1), i=0..7, out_ready=1 -> products 0,2,6,12,20,30,42,56 in order, one per cycle at steady state, no drops.
REQ-036 Backpressure: out_ready=0, offer 10 pairs -> exactly DEPTH results held plus DEPTH accepted into the input queue, in_ready=0 thereafter, no issue while outstanding=DEPTH; release out_ready -> all 10 results in order.
REQ-037 Extremes: in_a=0x80000000, in_b=0x80000000 -> out_prod=0x4000000000000000; in_a=0xFFFFFFFF, in_b=0x00000001 -> out_prod=0xFFFFFFFFFFFFFFFF.
REQ-038 Reset mid-flight: assert RST with 2 items in flight and 3 queued -> all outputs at reset values immediately; after deassertion, one new pair 7x6 -> only out_prod=42 emerges.
REQ-039 Wrap: 3*DEPTH+1 items with random out_ready stalls -> scoreboard match, no overflow or underflow assertion fires.
